display_scan_controller: RTL and testbench
==========================================

# display_scan_controller

Time-multiplexing scan controller for the 4-digit seven-segment display, directly upstream of the anode decoder. It generates the 2-bit digit select that drives the anode decoder. It also presents the matching 4-bit hex nibble and blank flag to the segment encoder. A 16-bit display value is accepted through a load handshake and committed only at a frame boundary, so a digit scan never shows a mix of old and new values.

## Interface

- CLK_DIV, default 100000: clock cycles each digit is held; must be ≥ 2. At 100 MHz the default gives a 1 kHz digit rate.

- clk, input, 1: system clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- value_in, input, 16: display value; nibble k is shown on digit k, and digit 0 is the rightmost.
- load, input, 1: single-cycle request to capture value_in.
- blank_lz, input, 1: enables leading-zero blanking; sampled combinationally.
- digit_sel, output, 2: active digit index; feeds the anode decoder select.
- hex_out, output, 4: nibble for the active digit.
- blank, output, 1: active digit must be dark; the segment encoder forces all segments off.
- update, output, 1: one-cycle pulse when a new value becomes the displayed value.

## Operation

- **Registers**
  - prescaler counter, width $clog2(CLK_DIV)
  - digit_sel, 2 bits
  - shown, 16 bits
  - pending, 16 bits
  - pending_valid, 1 bit
  - update, 1 bit
- **Prescaler**
  - Counts 0 … CLK_DIV-1, then wraps to 0.
  - tick = (count == CLK_DIV-1).
- **Digit scan**
  - On tick, digit_sel increments modulo 4: 0→1→2→3→0.
  - Frame boundary = tick while digit_sel == 3.
- **Load handling**
  - load outside a frame boundary: pending ← value_in, pending_valid ← 1. A later load before the boundary overwrites pending; the latest load wins.
  - Frame boundary with pending_valid = 1 and load = 0: shown ← pending, pending_valid ← 0, update ← 1.
  - Frame boundary with load = 1: shown ← value_in directly, pending_valid ← 0, update ← 1. The stale pending value is discarded.
  - Frame boundary with no pending value and no load: shown unchanged, update ← 0.
  - update is 0 in every cycle other than the cycle after a commit.
- **Outputs**
  - hex_out = shown[4·digit_sel +: 4]; combinational from registers, with no extra latency.
  - blank = blank_lz AND digit_sel ≠ 0 AND every nibble of shown from index digit_sel up to 3 is zero.
  - Digit 0 is never blanked. A nonzero nibble un-blanks itself and every digit below it.
- **Reset** (asynchronous)
  - count = 0, digit_sel = 0, shown = 0, pending = 0, pending_valid = 0, update = 0.
  - This gives hex_out = 0 and blank = 0.
  - Reset mid-frame discards any pending value; no update follows reset release.

## Timing

- After reset release, digit_sel holds 0 for exactly CLK_DIV cycles. Each later digit is also held for CLK_DIV cycles, so one frame = 4·CLK_DIV cycles.
- The digit_sel change and the shown commit happen on the same clock edge. update is high for the one cycle in which digit_sel first reads 0 of the new frame.
- Load-to-display latency: from 1 to 4·CLK_DIV cycles, depending on the frame position.
- hex_out and blank change in the same cycle as digit_sel, because they share the same registers. No output is ever out of phase with digit_sel.
- Simultaneous load and reset: reset dominates; the load is lost.

## Test plan

All scenarios use CLK_DIV = 4.

1. **Reset and scan order.** Assert reset, then release. Outputs: digit_sel = 0, hex_out = 0, blank = 0, update = 0. digit_sel then steps to 1, 2, 3, 0 at cycles 4, 8, 12 and 16 after release.
2. **Deferred commit.** Pulse load with 0x1234 at cycle 6.
   - hex_out stays 0 through cycle 15.
   - At cycle 16, update = 1 for one cycle.
   - Over the next frame, hex_out = 4, 3, 2, 1 for digit_sel = 0, 1, 2, 3.
3. **Latest load wins.** Pulse load with 0xAAAA at cycle 2 and with 0x5555 at cycle 9. Only 0x5555 is ever displayed, and exactly one update pulse occurs, at cycle 16.
4. **Leading-zero blanking.** Set blank_lz = 1.
   - Display 0x0070: blank = 1 on digits 3 and 2; blank = 0 on digit 1 (hex 7) and digit 0 (hex 0).
   - Display 0x0000: only digit 0 is unblanked.
   - Set blank_lz = 0: no digit is blanked.
5. **Load on the boundary cycle.** Pulse load with 0xBEEF in the cycle where digit_sel = 3 and count = 3, while 0x1111 is pending.
   - Digit 0 of the next frame shows F, and update pulses in that cycle.
   - 0x1111 is never displayed.
6. **Reset mid-operation.** Pulse load with 0x9999 at cycle 5, then assert reset at cycle 7 and release it.
   - After release, shown = 0 and digit_sel restarts at 0.
   - No update pulse occurs in the following two frames.

Source files
------------

// File: rtl/display_scan_controller.sv
// Time-multiplexed scan controller for a 4-digit seven-segment display.
// New display values are staged and committed only at a frame boundary.
module display_scan_controller #(
    parameter int CLK_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic [1:0]  digit_sel,
    output logic [3:0]  hex_out,
    output logic        blank,
    output logic        update
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(CLK_DIV - 1);

    logic [CW-1:0] count_r;
    logic [1:0]    digit_sel_r;
    logic [15:0]   shown_r;
    logic [15:0]   pending_r;
    logic          pending_valid_r;
    logic          update_r;

    logic          tick_s;
    logic          boundary_s;
    logic [3:0]    hex_s;
    logic          blank_s;

    assign tick_s     = (count_r == LAST_COUNT);
    assign boundary_s = tick_s && (digit_sel_r == 2'd3);

    // Prescaler: sets how long each digit stays lit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= {CW{1'b0}};
        end else if (tick_s) begin
            count_r <= {CW{1'b0}};
        end else begin
            count_r <= count_r + CW'(1);
        end
    end

    // Digit index advances once per prescaler period and wraps 3 -> 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_sel_r <= 2'd0;
        end else if (tick_s) begin
            digit_sel_r <= digit_sel_r + 2'd1;
        end else begin
            digit_sel_r <= digit_sel_r;
        end
    end

    // Staging and frame-aligned commit; a load on the boundary itself bypasses pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shown_r         <= 16'h0000;
            pending_r       <= 16'h0000;
            pending_valid_r <= 1'b0;
            update_r        <= 1'b0;
        end else if (boundary_s) begin
            if (load) begin
                shown_r         <= value_in;
                pending_valid_r <= 1'b0;
                update_r        <= 1'b1;
            end else if (pending_valid_r) begin
                shown_r         <= pending_r;
                pending_valid_r <= 1'b0;
                update_r        <= 1'b1;
            end else begin
                update_r        <= 1'b0;
            end
        end else begin
            update_r <= 1'b0;
            if (load) begin
                pending_r       <= value_in;
                pending_valid_r <= 1'b1;
            end
        end
    end

    // Nibble select and leading-zero blanking, both derived from the same registers as digit_sel.
    always_comb begin
        hex_s   = 4'h0;
        blank_s = 1'b0;
        case (digit_sel_r)
            2'd0: begin
                hex_s   = shown_r[3:0];
                blank_s = 1'b0;
            end
            2'd1: begin
                hex_s   = shown_r[7:4];
                blank_s = blank_lz && (shown_r[15:4] == 12'h000);
            end
            2'd2: begin
                hex_s   = shown_r[11:8];
                blank_s = blank_lz && (shown_r[15:8] == 8'h00);
            end
            2'd3: begin
                hex_s   = shown_r[15:12];
                blank_s = blank_lz && (shown_r[15:12] == 4'h0);
            end
            default: begin
                hex_s   = 4'h0;
                blank_s = 1'b0;
            end
        endcase
    end

    assign digit_sel = digit_sel_r;
    assign hex_out   = hex_s;
    assign blank     = blank_s;
    assign update    = update_r;

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: directed tables and sequences plus random
// traffic checked against a cycle-count based reference model.
module tb_display_scan_controller;

    localparam int CD = 4;
    localparam int FRAME = 4 * CD;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value_in = 16'h0000;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [1:0]  digit_sel;
    logic [3:0]  hex_out;
    logic        blank;
    logic        update;

    int checks = 0;
    int errors = 0;

    // Reference model state: cycles since reset release plus committed/staged values.
    int          m_t;
    logic [15:0] m_shown;
    logic [15:0] m_pend;
    bit          m_pv;
    bit          m_upd;

    display_scan_controller #(.CLK_DIV(CD)) dut (
        .clk(clk), .reset(reset), .value_in(value_in), .load(load),
        .blank_lz(blank_lz), .digit_sel(digit_sel), .hex_out(hex_out),
        .blank(blank), .update(update)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int         cyc;
        logic [1:0] sel;
        logic [3:0] hex;
        logic       upd;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_shown = 16'h0000; m_pend = 16'h0000; m_pv = 1'b0; m_upd = 1'b0;
    endtask

    task automatic model_step(input bit ld, input logic [15:0] v);
        if ((m_t % FRAME) == FRAME - 1) begin
            if (ld) begin
                m_shown = v; m_upd = 1'b1;
            end else if (m_pv) begin
                m_shown = m_pend; m_upd = 1'b1;
            end else begin
                m_upd = 1'b0;
            end
            m_pv = 1'b0;
        end else begin
            m_upd = 1'b0;
            if (ld) begin
                m_pend = v; m_pv = 1'b1;
            end
        end
        m_t++;
    endtask

    task automatic model_check();
        int d;
        bit zeros_above;
        logic [15:0] sh;
        d = (m_t / CD) % 4;
        sh = m_shown >> (4 * d);
        zeros_above = 1'b1;
        for (int k = d; k < 4; k++) begin
            if (m_shown[4*k +: 4] != 4'h0) zeros_above = 1'b0;
        end
        chk("model_digit_sel", 32'(digit_sel), 32'(d));
        chk("model_hex_out", 32'(hex_out), 32'(sh[3:0]));
        chk("model_blank", 32'(blank), 32'(blank_lz && (d != 0) && zeros_above));
        chk("model_update", 32'(update), 32'(m_upd));
    endtask

    // One cycle: drive inputs, check against model, clock, advance model.
    task automatic apply(input bit ld, input logic [15:0] v, input bit blz);
        load = ld; value_in = v; blank_lz = blz;
        #1;
        model_check();
        @(posedge clk);
        model_step(ld, v);
        @(negedge clk);
    endtask

    task automatic do_reset();
        load = 1'b0; value_in = 16'h0000; reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_digit_sel", 32'(digit_sel), 32'd0);
        chk("reset_hex_out", 32'(hex_out), 32'd0);
        chk("reset_blank", 32'(blank), 32'd0);
        chk("reset_update", 32'(update), 32'd0);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int upd_cnt;
        int upd_cyc;
        int bad_cnt;
        bit blz;
        int d;

        tbl[0]  = '{0,  2'd0, 4'h0, 1'b0};
        tbl[1]  = '{3,  2'd0, 4'h0, 1'b0};
        tbl[2]  = '{4,  2'd1, 4'h0, 1'b0};
        tbl[3]  = '{8,  2'd2, 4'h0, 1'b0};
        tbl[4]  = '{12, 2'd3, 4'h0, 1'b0};
        tbl[5]  = '{15, 2'd3, 4'h0, 1'b0};
        tbl[6]  = '{16, 2'd0, 4'h4, 1'b1};
        tbl[7]  = '{17, 2'd0, 4'h4, 1'b0};
        tbl[8]  = '{20, 2'd1, 4'h3, 1'b0};
        tbl[9]  = '{24, 2'd2, 4'h2, 1'b0};
        tbl[10] = '{28, 2'd3, 4'h1, 1'b0};
        tbl[11] = '{32, 2'd0, 4'h4, 1'b0};

        // Reset, scan order and deferred commit of 0x1234 loaded at cycle 6.
        do_reset();
        for (int c = 0; c <= 32; c++) begin
            load = (c == 6); value_in = 16'h1234; blank_lz = 1'b0;
            #1;
            for (int i = 0; i < 12; i++) begin
                if (tbl[i].cyc == c) begin
                    chk("tbl_digit_sel", 32'(digit_sel), 32'(tbl[i].sel));
                    chk("tbl_hex_out", 32'(hex_out), 32'(tbl[i].hex));
                    chk("tbl_update", 32'(update), 32'(tbl[i].upd));
                    chk("tbl_blank", 32'(blank), 32'd0);
                end
            end
            apply(c == 6, 16'h1234, 1'b0);
        end

        // Latest load wins.
        do_reset();
        upd_cnt = 0; upd_cyc = -1; bad_cnt = 0;
        for (int c = 0; c <= 32; c++) begin
            #1;
            if (update === 1'b1) begin upd_cnt++; upd_cyc = c; end
            if (hex_out === 4'hA) bad_cnt++;
            apply((c == 2) || (c == 9), (c == 2) ? 16'hAAAA : 16'h5555, 1'b0);
        end
        chk("latest_upd_count", 32'(upd_cnt), 32'd1);
        chk("latest_upd_cycle", 32'(upd_cyc), 32'd16);
        chk("latest_no_stale", 32'(bad_cnt), 32'd0);

        // Leading-zero blanking.
        do_reset();
        for (int c = 0; c < 80; c++) begin
            blz = (c < 64);
            load = (c == 0) || (c == 32); value_in = (c == 0) ? 16'h0070 : 16'h0000;
            blank_lz = blz;
            #1;
            d = (c / CD) % 4;
            if (c >= 16 && c < 32) begin
                chk("lz_0070_blank", 32'(blank), 32'(d >= 2));
                chk("lz_0070_hex", 32'(hex_out), (d == 1) ? 32'h7 : 32'h0);
            end else if (c >= 48 && c < 64) begin
                chk("lz_0000_blank", 32'(blank), 32'(d != 0));
            end else if (c >= 64) begin
                chk("lz_off_blank", 32'(blank), 32'd0);
            end
            apply((c == 0) || (c == 32), (c == 0) ? 16'h0070 : 16'h0000, blz);
        end

        // Load on the boundary cycle while 0x1111 is pending.
        do_reset();
        bad_cnt = 0;
        for (int c = 0; c < 48; c++) begin
            #1;
            if (c == 16) begin
                chk("bnd_hex_out", 32'(hex_out), 32'hF);
                chk("bnd_update", 32'(update), 32'd1);
                chk("bnd_digit_sel", 32'(digit_sel), 32'd0);
            end
            if (c >= 16 && hex_out === 4'h1) bad_cnt++;
            apply((c == 5) || (c == 15), (c == 5) ? 16'h1111 : 16'hBEEF, 1'b0);
        end
        chk("bnd_stale_never_shown", 32'(bad_cnt), 32'd0);

        // Reset mid-operation discards pending value.
        do_reset();
        for (int c = 0; c < 7; c++) begin
            apply(c == 5, 16'h9999, 1'b0);
        end
        reset = 1'b1;
        #1;
        chk("midrst_digit_sel", 32'(digit_sel), 32'd0);
        chk("midrst_update", 32'(update), 32'd0);
        do_reset();
        upd_cnt = 0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            #1;
            if (update === 1'b1) upd_cnt++;
            apply(1'b0, 16'h0000, 1'b0);
        end
        chk("midrst_no_update", 32'(upd_cnt), 32'd0);
        chk("midrst_hex_zero", 32'(hex_out), 32'd0);

        // Random traffic against the model.
        do_reset();
        blz = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 19) == 0) blz = ~blz;
            apply($urandom_range(0, 5) == 0, 16'($urandom), blz);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
